// File: rtl/sel_sequencer_pkg.sv
// Shared types and constants for the selector sequencer.
// The default arm of the downstream decoder catches codes with bit 0 set.
package sel_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_00 = 2'b00;
  localparam logic [1:0] SEL_01 = 2'b01;
  localparam logic [1:0] SEL_10 = 2'b10;
  localparam logic [1:0] SEL_11 = 2'b11;

  function automatic logic is_dflt(input logic [1:0] code);
    return (code == SEL_01) || (code == SEL_11);
  endfunction

endpackage

// File: rtl/sel_fifo.sv
// Purpose: DEPTH x 2-bit synchronous FIFO holding programmed selector codes.
// Latency: a push is visible at head the cycle after it is written; head is combinational.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module sel_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       pop,
  output logic [1:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  mem [DEPTH];

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_code;
  end

endmodule

// File: rtl/sel_sequencer.sv
// Purpose: buffers selector codes and replays them to the decoder, each held HOLD cycles (SEL_SKIP_DEFAULT_EN drops default-arm codes at load).
// Latency: handshake at cycle t gives the next sel_valid at t+HOLD+1; done pulses HOLD+1 cycles after the last handshake.
// Backpressure: sel held indefinitely while sel_ready is low; load_ready low outside IDLE or when the buffer is full.
module sel_sequencer
  import sel_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 10,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       load_code,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  output logic [1:0]       sel,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             sel_dflt,
  output logic             busy,
  output logic             done,
`ifdef SEL_SKIP_DEFAULT_EN
  output logic [CNT_W-1:0] skip_cnt,
`endif
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int            HW      = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    sel_q;
  logic [1:0]    head;
  logic          full, empty;
  logic          load_fire, skip, push, hs;

  assign load_fire = load_valid && load_ready;
`ifdef SEL_SKIP_DEFAULT_EN
  assign skip      = load_code[0];
`else
  assign skip      = 1'b0;
`endif
  assign push      = load_fire && !skip;
  assign hs        = sel_valid && sel_ready;

  sel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_code (load_code),
    .pop       (hs),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    sel_valid  = 1'b0;
    sel        = sel_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = !full;
        // A push landing on the same edge as start counts as buffered content.
        if (start && (!empty || push))
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        sel       = head;
        sel_valid = 1'b1;
        busy      = 1'b1;
        if (sel_ready)
          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (hold_cnt == '0)
          state_nxt = empty ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef SEL_SKIP_DEFAULT_EN
    sel_dflt = 1'b0;
`else
    sel_dflt = is_dflt(sel);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      sel_q    <= SEL_00;
      sent_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        sel_q    <= head;
        hold_cnt <= HOLD_LD;
        if (sent_cnt != '1)
          sent_cnt <= sent_cnt + CNT_W'(1);
      end else if (state == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

`ifdef SEL_SKIP_DEFAULT_EN
  always_ff @(posedge clock) begin
    if (reset)
      skip_cnt <= '0;
    else if (load_fire && skip && skip_cnt != '1)
      skip_cnt <= skip_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_sel_sequencer.sv
// Scoreboard bench for sel_sequencer: stimulus queues expected codes, a negedge monitor checks each handshake.
module tb_sel_sequencer;
  import sel_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 10;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       load_code;
  logic             load_valid;
  logic             load_ready;
  logic             start;
  logic [1:0]       sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             sel_dflt;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;
`ifdef SEL_SKIP_DEFAULT_EN
  logic [CNT_W-1:0] skip_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cyc = 0;
  logic [1:0] exp_q[$];
  int         hs_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sel_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_code  (load_code),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .start      (start),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_dflt   (sel_dflt),
    .busy       (busy),
    .done       (done),
`ifdef SEL_SKIP_DEFAULT_EN
    .skip_cnt   (skip_cnt),
`endif
    .sent_cnt   (sent_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected code from the scoreboard.
  always @(negedge clock) begin
    if (!reset && sel_valid && sel_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", {30'd0, sel}, 32'hFFFF_FFFF);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("sel_code", {30'd0, sel}, {30'd0, e});
`ifdef SEL_SKIP_DEFAULT_EN
        check("sel_dflt", {31'd0, sel_dflt}, 32'd0);
`else
        check("sel_dflt", {31'd0, sel_dflt}, {31'd0, e[0]});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] code);
    load_code  = code;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    done_cyc = cyc;
    check(name, {31'd0, done}, 32'd1);
    tick();
    check({name, "_pulse_end"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_code  = 2'b00;
    load_valid = 1'b0;
    start      = 1'b0;
    sel_ready  = 1'b0;
    do_reset();

    check("rst_sel",        {30'd0, sel},       32'd0);
    check("rst_sel_valid",  {31'd0, sel_valid}, 32'd0);
    check("rst_sel_dflt",   {31'd0, sel_dflt},  32'd0);
    check("rst_busy",       {31'd0, busy},      32'd0);
    check("rst_done",       {31'd0, done},      32'd0);
    check("rst_sent_cnt",   {24'd0, sent_cnt},  32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);

    // Basic playback of 00, 10 with ready always high.
    load(SEL_00); exp_q.push_back(SEL_00);
    load(SEL_10); exp_q.push_back(SEL_10);
    sel_ready = 1'b1;
    do_start();
    wait_done("t1_done");
    check("t1_sent_cnt", {24'd0, sent_cnt}, 32'd2);
    check("t1_hs_count", hs_q.size(), 32'd2);
    if (hs_q.size() == 2) begin
      check("t1_hs_gap",   hs_q[1] - hs_q[0],   HOLD + 1);
      check("t1_done_gap", done_cyc - hs_q[1],  HOLD + 1);
    end
    check("t1_sel_kept", {30'd0, sel}, {30'd0, SEL_10});
    check("t1_busy", {31'd0, busy}, 32'd0);
    hs_q.delete();

`ifndef SEL_SKIP_DEFAULT_EN
    // Fill the buffer, try a fifth load, then stall in RUN.
    sel_ready = 1'b0;
    load(SEL_00); exp_q.push_back(SEL_00);
    load(SEL_01); exp_q.push_back(SEL_01);
    load(SEL_10); exp_q.push_back(SEL_10);
    check("t2_ready_before_full", {31'd0, load_ready}, 32'd1);
    load(SEL_11); exp_q.push_back(SEL_11);
    check("t2_ready_full", {31'd0, load_ready}, 32'd0);
    load(SEL_10);
    do_start();
    for (int i = 0; i < 20; i++) begin
      check("t2_stall_sel",   {30'd0, sel},       32'd0);
      check("t2_stall_valid", {31'd0, sel_valid}, 32'd1);
      tick();
    end
    check("t2_stall_sent", {24'd0, sent_cnt}, 32'd2);
    sel_ready = 1'b1;
    wait_done("t2_done");
    check("t2_sent_cnt", {24'd0, sent_cnt}, 32'd6);
    check("t2_scoreboard_drained", exp_q.size(), 32'd0);

    // Reset while holding with two codes still buffered.
    load(SEL_10); exp_q.push_back(SEL_10);
    load(SEL_01);
    load(SEL_11);
    do_start();
    for (int i = 0; i < 20 && sent_cnt != 8'd7; i++) tick();
    check("t3_first_hs", {24'd0, sent_cnt}, 32'd7);
    tick(); tick();
    check("t3_in_hold", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t3_busy",       {31'd0, busy},       32'd0);
    check("t3_sel",        {30'd0, sel},        32'd0);
    check("t3_sel_valid",  {31'd0, sel_valid},  32'd0);
    check("t3_load_ready", {31'd0, load_ready}, 32'd1);
    // Start with the buffer empty must do nothing.
    do_start();
    for (int i = 0; i < 5; i++) begin
      check("t4_idle_busy",  {31'd0, busy},      32'd0);
      check("t4_idle_done",  {31'd0, done},      32'd0);
      check("t4_idle_valid", {31'd0, sel_valid}, 32'd0);
      tick();
    end
    // Discarded codes must not reappear after reset.
    load(SEL_11); exp_q.push_back(SEL_11);
    do_start();
    wait_done("t5_done");
    check("t5_sent_cnt", {24'd0, sent_cnt}, 32'd1);
    check("t5_scoreboard_drained", exp_q.size(), 32'd0);
`else
    // Default-arm codes are accepted at load but never played.
    do_reset();
    load(SEL_01);
    load(SEL_00); exp_q.push_back(SEL_00);
    load(SEL_11);
    check("m_load_ready", {31'd0, load_ready}, 32'd1);
    check("m_skip_cnt",   {24'd0, skip_cnt},   32'd2);
    do_start();
    wait_done("m_done");
    check("m_sent_cnt", {24'd0, sent_cnt}, 32'd1);
    check("m_hs_count", hs_q.size(), 32'd1);
    check("m_sel_dflt", {31'd0, sel_dflt}, 32'd0);
    check("m_scoreboard_drained", exp_q.size(), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
